// File: rtl/idex_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/EX/MEM/CP0 status in, pipeline controls out.
// master = pipeline side, slave = hazard controller.
interface idex_hazard_ctrl_if;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        ex_regwr;
    logic        ex_memtoreg;
    logic [4:0]  ex_regdst_addr;
    logic        id_mdu_start;
    logic        id_mdu_use;
    logic        dmem_busy;
    logic        exc_req;
    logic        pc_stall;
    logic        ifid_stall;
    logic        pa_idexmemwr;
    logic        wash_ifid;
    logic        wash_idex;
    logic        exc_taken;
    logic        mdu_busy;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs_addr, id_rt_addr,
        output id_rs_used, id_rt_used,
        output ex_regwr, ex_memtoreg,
        output ex_regdst_addr,
        output id_mdu_start, id_mdu_use,
        output dmem_busy, exc_req,
        input  pc_stall, ifid_stall,
        input  pa_idexmemwr,
        input  wash_ifid, wash_idex,
        input  exc_taken, mdu_busy,
        input  stall_cycles
    );

    modport slave (
        input  id_rs_addr, id_rt_addr,
        input  id_rs_used, id_rt_used,
        input  ex_regwr, ex_memtoreg,
        input  ex_regdst_addr,
        input  id_mdu_start, id_mdu_use,
        input  dmem_busy, exc_req,
        output pc_stall, ifid_stall,
        output pa_idexmemwr,
        output wash_ifid, wash_idex,
        output exc_taken, mdu_busy,
        output stall_cycles
    );
endinterface

// File: rtl/idex_hazard_ctrl.sv
// ID/EX hazard and sequencing controller: load-use, MDU busy,
// data-memory wait and exception flush.
module idex_hazard_ctrl #(
    parameter int MDU_LAT   = 32,
    parameter int EXC_FLUSH = 2
) (
    input logic clk,
    input logic reset,
    idex_hazard_ctrl_if.slave hz
);

    typedef enum logic {RUN, EXC} state_t;

    localparam logic [5:0] MDU_LOAD   = 6'(MDU_LAT);
    localparam logic [1:0] FLUSH_LOAD = 2'(EXC_FLUSH - 1);

    state_t      state_q, state_d;
    logic [5:0]  mdu_cnt_q, mdu_cnt_d;
    logic        exc_pend_q, exc_pend_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] stall_q;

    logic hit_rs, hit_rt;
    logic load_use, mdu_haz;
    logic exc_take, mdu_enter;

    logic pc_stall_c, ifid_stall_c, pa_c;
    logic wash_ifid_c, wash_idex_c, exc_taken_c;

    assign hit_rs = hz.id_rs_used
                  & (hz.id_rs_addr == hz.ex_regdst_addr);
    assign hit_rt = hz.id_rt_used
                  & (hz.id_rt_addr == hz.ex_regdst_addr);

    assign load_use = hz.ex_memtoreg & hz.ex_regwr
                    & (hz.ex_regdst_addr != 5'd0)
                    & (hit_rs | hit_rt);

    assign mdu_haz = hz.id_mdu_use & (mdu_cnt_q != 6'd0);

    assign exc_take = (hz.exc_req | exc_pend_q)
                    & ~hz.dmem_busy
                    & (state_q == RUN);

    always_comb begin
        pc_stall_c   = 1'b0;
        ifid_stall_c = 1'b0;
        pa_c         = 1'b0;
        wash_ifid_c  = 1'b0;
        wash_idex_c  = 1'b0;
        exc_taken_c  = 1'b0;
        if (reset) begin
            pc_stall_c = 1'b0;
        end else if (hz.dmem_busy) begin
            pc_stall_c   = 1'b1;
            ifid_stall_c = 1'b1;
            pa_c         = 1'b1;
        end else if (exc_take) begin
            exc_taken_c = 1'b1;
            wash_ifid_c = 1'b1;
            wash_idex_c = 1'b1;
        end else if (state_q == EXC) begin
            wash_ifid_c = 1'b1;
        end else if (mdu_haz | load_use) begin
            // one bubble per cycle even when both hazards coincide
            pc_stall_c   = 1'b1;
            ifid_stall_c = 1'b1;
            wash_idex_c  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            RUN: begin
                if (exc_take) begin
                    state_d     = EXC;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            EXC: begin
                if (!hz.dmem_busy) begin
                    if (flush_cnt_q == 2'd0)
                        state_d = RUN;
                    else
                        flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // requests arriving during EXC are not latched
    always_comb begin
        exc_pend_d = exc_pend_q;
        if (exc_take)
            exc_pend_d = 1'b0;
        else if (hz.exc_req & hz.dmem_busy & (state_q == RUN))
            exc_pend_d = 1'b1;
    end

    assign mdu_enter = hz.id_mdu_start & ~pa_c & ~wash_idex_c;

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_enter)
            mdu_cnt_d = MDU_LOAD;
        else if (mdu_cnt_q != 6'd0)
            mdu_cnt_d = mdu_cnt_q - 6'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            mdu_cnt_q   <= 6'd0;
            exc_pend_q  <= 1'b0;
            flush_cnt_q <= 2'd0;
            stall_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            exc_pend_q  <= exc_pend_d;
            flush_cnt_q <= flush_cnt_d;
            stall_q     <= stall_q + 32'(pc_stall_c);
        end
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.ifid_stall   = ifid_stall_c;
    assign hz.pa_idexmemwr = pa_c;
    assign hz.wash_ifid    = wash_ifid_c;
    assign hz.wash_idex    = wash_idex_c;
    assign hz.exc_taken    = exc_taken_c;
    assign hz.mdu_busy     = (mdu_cnt_q != 6'd0);
    assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Bench for idex_hazard_ctrl: vector table, directed corner
// sequences and random stimulus against a rule-level model.
module tb_idex_hazard_ctrl;

    localparam int MDU_LAT   = 32;
    localparam int EXC_FLUSH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    idex_hazard_ctrl_if hz();

    idex_hazard_ctrl #(
        .MDU_LAT(MDU_LAT),
        .EXC_FLUSH(EXC_FLUSH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic       regwr;
        logic       memtoreg;
        logic [4:0] rd;
        logic       mdu_start;
        logic       mdu_use;
        logic       dmem_busy;
        logic       exc_req;
    } in_t;

    typedef struct {
        in_t        in;
        logic [5:0] exp;
        string      name;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // {pc_stall, ifid_stall, pa, wash_ifid, wash_idex, exc_taken}
    logic [5:0] outv;
    assign outv = {hz.pc_stall, hz.ifid_stall, hz.pa_idexmemwr,
                   hz.wash_ifid, hz.wash_idex, hz.exc_taken};

    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_BUB  = 6'b110010;
    localparam logic [5:0] O_WAIT = 6'b111000;
    localparam logic [5:0] O_TAKE = 6'b000111;
    localparam logic [5:0] O_EXC  = 6'b000100;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input in_t v);
        hz.id_rs_addr     = v.rs;
        hz.id_rt_addr     = v.rt;
        hz.id_rs_used     = v.rs_used;
        hz.id_rt_used     = v.rt_used;
        hz.ex_regwr       = v.regwr;
        hz.ex_memtoreg    = v.memtoreg;
        hz.ex_regdst_addr = v.rd;
        hz.id_mdu_start   = v.mdu_start;
        hz.id_mdu_use     = v.mdu_use;
        hz.dmem_busy      = v.dmem_busy;
        hz.exc_req        = v.exc_req;
    endtask

    task automatic cyc(input in_t v);
        @(negedge clk);
        apply(v);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        apply('0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic in_t lu(input logic [4:0] r, input logic busy);
        in_t v;
        v = '0;
        v.rs = r;
        v.rs_used = 1'b1;
        v.regwr = 1'b1;
        v.memtoreg = 1'b1;
        v.rd = r;
        v.dmem_busy = busy;
        return v;
    endfunction

    vec_t tbl[10];

    int m_mdu, m_flush;
    bit m_pend;
    logic [31:0] m_stalls;

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        in_t v;
        in_t idle;
        int n;
        idle = '0;
        apply(idle);

        tbl[0] = '{lu(5'd5, 1'b0), O_BUB, "lu_rs"};
        tbl[1] = '{lu(5'd0, 1'b0), O_NONE, "lu_r0"};
        v = lu(5'd7, 1'b0); v.rs = 5'd3; v.rt = 5'd7; v.rt_used = 1'b1;
        tbl[2] = '{v, O_BUB, "lu_rt"};
        v.rt_used = 1'b0;
        tbl[3] = '{v, O_NONE, "lu_rt_unused"};
        v = lu(5'd5, 1'b0); v.regwr = 1'b0;
        tbl[4] = '{v, O_NONE, "lu_no_regwr"};
        v = lu(5'd5, 1'b0); v.memtoreg = 1'b0;
        tbl[5] = '{v, O_NONE, "lu_not_load"};
        tbl[6] = '{lu(5'd5, 1'b1), O_WAIT, "lu_memwait"};
        v = lu(5'd5, 1'b0); v.rd = 5'd6;
        tbl[7] = '{v, O_NONE, "lu_no_match"};
        v = '0; v.dmem_busy = 1'b1;
        tbl[8] = '{v, O_WAIT, "memwait"};
        v = '0; v.mdu_use = 1'b1;
        tbl[9] = '{v, O_NONE, "mdu_idle_use"};

        // reset state
        @(negedge clk);
        v = lu(5'd5, 1'b1); v.exc_req = 1'b1;
        apply(v);
        #2;
        check("reset_outs", outv, O_NONE);
        check("reset_busy", hz.mdu_busy, 0);
        check("reset_stall", hz.stall_cycles, 0);
        apply(idle);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].in);
            check(tbl[i].name, outv, tbl[i].exp);
        end

        // load-use then bubble in EX
        do_reset();
        cyc(lu(5'd5, 1'b0));
        check("seq_lu_stall", outv, O_BUB);
        v = lu(5'd5, 1'b0); v.regwr = 1'b0; v.memtoreg = 1'b0;
        cyc(v);
        check("seq_lu_after", outv, O_NONE);
        check("seq_lu_count", hz.stall_cycles, 1);

        // div then mfhi one cycle later
        do_reset();
        v = '0; v.mdu_start = 1'b1; v.mdu_use = 1'b1;
        cyc(v);
        check("mdu_issue", outv, O_NONE);
        cyc(idle);
        check("mdu_busy_on", hz.mdu_busy, 1);
        v = '0; v.mdu_use = 1'b1;
        n = 0;
        cyc(v);
        while (outv == O_BUB && n < 100) begin
            n++;
            cyc(v);
        end
        check("mdu_stall_len", n, MDU_LAT - 1);
        check("mdu_proceed", outv, O_NONE);
        check("mdu_busy_off", hz.mdu_busy, 0);

        // memory wait over load-use while MDU counts
        do_reset();
        v = '0; v.mdu_start = 1'b1;
        cyc(v);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(lu(5'd5, 1'b1));
            n++;
            check("mw_wait", outv, O_WAIT);
        end
        cyc(lu(5'd5, 1'b0));
        n++;
        check("mw_resume", outv, O_BUB);
        cyc(idle);
        n++;
        while (hz.mdu_busy && n < 100) begin
            cyc(idle);
            n++;
        end
        check("mw_mdu_len", n, MDU_LAT + 1);

        // exception request during memory wait
        do_reset();
        v = '0; v.dmem_busy = 1'b1; v.exc_req = 1'b1;
        cyc(v);
        check("exc_wait1", outv, O_WAIT);
        v.exc_req = 1'b0;
        cyc(v);
        check("exc_wait2", outv, O_WAIT);
        cyc(idle);
        check("exc_take", outv, O_TAKE);
        cyc(idle);
        check("exc_flush1", outv, O_EXC);
        cyc(idle);
        check("exc_flush2", outv, O_EXC);
        cyc(idle);
        check("exc_done", outv, O_NONE);

        // async reset with MDU at 17 and FSM in EXC
        do_reset();
        v = '0; v.mdu_start = 1'b1;
        cyc(v);
        for (int i = 0; i < 14; i++) cyc(idle);
        v = '0; v.exc_req = 1'b1;
        cyc(v);
        check("rst_pre_take", outv, O_TAKE);
        cyc(idle);
        check("rst_pre_exc", outv, O_EXC);
        check("rst_pre_busy", hz.mdu_busy, 1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_outs", outv, O_NONE);
        check("rst_mid_busy", hz.mdu_busy, 0);
        check("rst_mid_stall", hz.stall_cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(lu(5'd5, 1'b0));
        check("rst_post_run", outv, O_BUB);
        check("rst_post_busy", hz.mdu_busy, 0);

        // random stimulus against the rule model
        do_reset();
        m_mdu = 0; m_flush = 0; m_pend = 0; m_stalls = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] e;
            bit busy, in_exc, take, mhaz, luh;
            v = '0;
            v.rs = 5'($urandom_range(0, 3));
            v.rt = 5'($urandom_range(0, 3));
            v.rd = 5'($urandom_range(0, 3));
            v.rs_used = 1'($urandom_range(0, 1));
            v.rt_used = 1'($urandom_range(0, 1));
            v.regwr = 1'($urandom_range(0, 1));
            v.memtoreg = 1'($urandom_range(0, 1));
            v.dmem_busy = ($urandom_range(0, 99) < 15);
            v.exc_req = ($urandom_range(0, 99) < 2);
            v.mdu_start = ($urandom_range(0, 99) < 3);
            v.mdu_use = v.mdu_start | ($urandom_range(0, 9) == 0);
            cyc(v);

            busy = v.dmem_busy;
            in_exc = (m_flush > 0);
            take = (v.exc_req || m_pend) && !busy && !in_exc;
            mhaz = v.mdu_use && (m_mdu > 0);
            luh = v.memtoreg && v.regwr && (v.rd != 0)
                && ((v.rs_used && v.rs == v.rd)
                 || (v.rt_used && v.rt == v.rd));
            if (busy) e = O_WAIT;
            else if (take) e = O_TAKE;
            else if (in_exc) e = O_EXC;
            else if (mhaz || luh) e = O_BUB;
            else e = O_NONE;

            check($sformatf("rand_%0d", i),
                  {outv, hz.mdu_busy, hz.stall_cycles},
                  {e, (m_mdu > 0), m_stalls});

            m_stalls = m_stalls + 32'(e[5]);
            if (v.mdu_start && !e[3] && !e[1]) m_mdu = MDU_LAT;
            else if (m_mdu > 0) m_mdu--;
            if (take) m_pend = 0;
            else if (v.exc_req && busy && !in_exc) m_pend = 1;
            if (take) m_flush = EXC_FLUSH;
            else if (in_exc && !busy) m_flush--;
        end

        // stall counter wrap
        do_reset();
        @(negedge clk);
        force dut.stall_q = 32'hFFFF_FFFF;
        #1 release dut.stall_q;
        apply(lu(5'd5, 1'b0));
        #1;
        check("wrap_stall", outv, O_BUB);
        cyc(idle);
        check("wrap_zero", hz.stall_cycles, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
